bit_scan_serializer: RTL and testbench
======================================

Name: bit_scan_serializer

Overview:
Sequential, parametrised successor to the combinational bit-loop blocks. It accepts a WIDTH-bit vector over a valid/ready handshake. It then emits the index of every set bit, one per output beat, in LSB-first or MSB-first order selected per vector. It sits between a request/flag vector producer and a downstream consumer that handles one index at a time.

Parameters:
WIDTH, 8, vector width; legal range 1..1024, power of two not required.
IDX_W, max(1,$clog2(WIDTH)), derived localparam; index width.
CNT_W, $clog2(WIDTH+1), derived localparam; beat ordinal width.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input vector valid
in_ready  output  1  block can accept a vector
in_data  input  WIDTH  vector to scan
in_msb_first  input  1  scan order for this vector, sampled at accept; 0 = LSB-first
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts beat
out_idx  output  IDX_W  index of the current set bit
out_cnt  output  CNT_W  1-based ordinal of the current beat; 0 on the none beat
out_none  output  1  beat reports an all-zero vector
out_last  output  1  final beat for this vector

Behaviour:
- One clock domain; reset is synchronous and active-high (clk, rst).
- States: IDLE, SCAN.
- Reset: state=IDLE, pending vector=0, stored mode=0, beat counter=0, out_valid=0, out_idx=0, out_cnt=0, out_none=0, out_last=0.
- While rst=1, in_ready=0 and out_valid=0.
- in_ready=1 exactly when state=IDLE and rst=0.
- Accept occurs on in_valid && in_ready. On accept: pending<=in_data, mode<=in_msb_first, counter<=0, state<=SCAN.
- Latency: the first beat is valid in the cycle after accept. No combinational path from in_* to out_*.
- In SCAN, out_valid=1. out_idx = lowest set bit of pending (mode 0) or highest set bit (mode 1), produced by a combinational priority encoder on registered state.
- out_cnt = counter+1. out_last=1 when pending has exactly one set bit.
- Stall: out_valid && !out_ready. All outputs hold stable; no state change.
- Beat handshake (out_valid && out_ready): clear the emitted bit in pending and increment counter. If out_last, state<=IDLE, so in_ready=1 in the next cycle.
- Zero vector: exactly one beat with out_none=1, out_last=1, out_idx=0, out_cnt=0. State returns to IDLE after that handshake.
- Throughput: a vector with k set bits occupies k beats plus 1 IDLE accept cycle, i.e. max(k,1)+1 cycles at full out_ready.
- No overlap: a new vector cannot be accepted during SCAN, including in the cycle of the last-beat handshake.
- Reset mid-scan: the vector is abandoned. In the cycle after rst falls, state is IDLE, out_valid=0 and in_ready=1. No residual beats are emitted.
- WIDTH=1: IDX_W=1, out_idx is always 0. Non-power-of-two WIDTH never produces an index >= WIDTH.
- out_valid must not drop while a beat is stalled (AXI-style stability rule); the bench asserts this.

Decomposition:
- Package bit_scan_pkg: typedef enum {IDLE, SCAN} scan_state_t; helper function idx_w(width).
- Sub-module prio_enc: parameter WIDTH; inputs vec and msb_first; outputs idx, found, onehot_last (popcount==1). Purely combinational, built with a for loop. Instantiated once.
- The top level holds the FSM, pending register, counter and handshake logic.

Test Plan:
- Walking one, WIDTH=8: in_data=1<<i for i=0..7, LSB-first, out_ready=1 -> exactly one beat each with idx=i, cnt=1, last=1, none=0; in_ready returns 1 one cycle after each beat.
- 8'b1010_0110 LSB-first, out_ready=1 -> beats on consecutive cycles: idx 1,2,5,7; cnt 1,2,3,4; last only on idx 7.
- 8'b1010_0110 MSB-first -> idx 7,5,2,1; cnt 1..4; last on idx 1.
- 8'h00 -> single beat: none=1, last=1, idx=0, cnt=0; then IDLE.
- 8'hFF with out_ready toggling 1,0,1,0 -> idx 0..7 each emitted once, outputs held during stalls, in_ready=0 until after the idx 7 handshake.
- 8'hFF, assert rst for 1 cycle after 2 beats -> next cycle out_valid=0, in_ready=1; then 8'h80 MSB-first -> single beat idx=7, cnt=1, last=1.
- Repeat the directed cases above at WIDTH=1 and WIDTH=5 to cover the width boundary conditions.

Source files
------------

// File: rtl/bit_scan_pkg.sv
// Shared types and width helpers for the bit-scan serializer.
package bit_scan_pkg;

  // IDLE accepts a vector; SCAN emits one index per beat until the vector is exhausted.
  typedef enum logic [0:0] {
    IDLE,
    SCAN
  } scan_state_t;

  // Index width for a given vector width; a 1-bit vector still needs a 1-bit index.
  function automatic int unsigned idx_w(input int unsigned width);
    int unsigned w;
    w = (width > 1) ? int'($clog2(width)) : 1;
    return w;
  endfunction

endpackage

// File: rtl/bit_scan_serializer_prio_enc.sv
// Combinational priority encoder: picks the lowest (or highest) set bit of vec and
// flags whether exactly one bit is set.
module prio_enc
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             msb_first,
  output logic [IDX_W-1:0] idx,
  output logic             found,
  output logic             onehot_last
);

  logic [WIDTH-1:0] vec_rev;
  logic [WIDTH-1:0] scan_vec;
  logic             multi;

  // Bit-reverse the vector so a single LSB-first scan serves both orders.
  always_comb begin
    vec_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      vec_rev[i] = vec[WIDTH-1-i];
    end
    scan_vec = msb_first ? vec_rev : vec;
  end

  // First hit in scan order wins; any later hit marks the vector as multi-bit.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    multi = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (scan_vec[i]) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found = 1'b1;
          idx   = msb_first ? IDX_W'(WIDTH - 1 - i) : IDX_W'(i);
        end
      end
    end
    onehot_last = found && !multi;
  end

endmodule

// File: rtl/bit_scan_serializer.sv
// Accepts a WIDTH-bit vector and emits the index of each set bit, one per beat,
// LSB-first or MSB-first as chosen per vector. An all-zero vector yields one "none" beat.
module bit_scan_serializer
  import bit_scan_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = idx_w(WIDTH),
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_none,
  output logic             out_last
);

  scan_state_t      state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] enc_idx;
  logic             enc_found;
  logic             enc_onehot;
  logic [WIDTH-1:0] clr_mask;
  logic             in_fire;
  logic             out_fire;
  logic             last_beat;

  prio_enc #(
    .WIDTH(WIDTH)
  ) u_prio_enc (
    .vec        (pending_q),
    .msb_first  (mode_q),
    .idx        (enc_idx),
    .found      (enc_found),
    .onehot_last(enc_onehot)
  );

  // Handshake and beat outputs decode registered state only, so in_* never reaches out_*.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == SCAN) && !rst;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    // A zero vector is its own final beat.
    last_beat = !enc_found || enc_onehot;
    out_none  = out_valid && !enc_found;
    out_last  = out_valid && last_beat;
    out_idx   = (out_valid && enc_found) ? enc_idx : '0;
    out_cnt   = (out_valid && enc_found) ? cnt_q + CNT_W'(1) : '0;
  end

  // One-hot mask of the bit being emitted, cleared from pending on handshake.
  always_comb begin
    clr_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      clr_mask[i] = enc_found && (IDX_W'(i) == enc_idx);
    end
  end

  // Next-state: load on accept, consume one bit per beat handshake, hold otherwise.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          pending_d = in_data;
          mode_d    = in_msb_first;
          cnt_d     = '0;
          state_d   = SCAN;
        end
      end
      SCAN: begin
        if (out_fire) begin
          pending_d = pending_q & ~clr_mask;
          cnt_d     = cnt_q + CNT_W'(1);
          // Returning to IDLE here means no accept can coincide with the last beat.
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset abandons any vector in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Directed bench for bit_scan_serializer at WIDTH = 8, 1 and 5. One instance is active at a
// time (selected by sel); the other two sit idle in IDLE.
module tb_bit_scan_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_msb_first = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_data = 8'h00;
  int         sel = 0;

  always #5 clk = ~clk;

  logic       ir8, ov8, none8, last8;
  logic [2:0] idx8;
  logic [3:0] cnt8;
  logic       ir1, ov1, none1, last1;
  logic [0:0] idx1;
  logic [0:0] cnt1;
  logic       ir5, ov5, none5, last5;
  logic [2:0] idx5;
  logic [2:0] cnt5;

  bit_scan_serializer #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 0)), .in_ready(ir8),
    .in_data(in_data), .in_msb_first(in_msb_first), .out_valid(ov8), .out_ready(out_ready),
    .out_idx(idx8), .out_cnt(cnt8), .out_none(none8), .out_last(last8)
  );

  bit_scan_serializer #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 1)), .in_ready(ir1),
    .in_data(in_data[0:0]), .in_msb_first(in_msb_first), .out_valid(ov1),
    .out_ready(out_ready), .out_idx(idx1), .out_cnt(cnt1), .out_none(none1),
    .out_last(last1)
  );

  bit_scan_serializer #(.WIDTH(5)) u_w5 (
    .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2)), .in_ready(ir5),
    .in_data(in_data[4:0]), .in_msb_first(in_msb_first), .out_valid(ov5),
    .out_ready(out_ready), .out_idx(idx5), .out_cnt(cnt5), .out_none(none5),
    .out_last(last5)
  );

  logic v_ir, v_ov, v_none, v_last;
  int   v_idx, v_cnt;

  always_comb begin
    v_ir = ir8; v_ov = ov8; v_none = none8; v_last = last8;
    v_idx = int'(idx8); v_cnt = int'(cnt8);
    case (sel)
      1: begin
        v_ir = ir1; v_ov = ov1; v_none = none1; v_last = last1;
        v_idx = int'(idx1); v_cnt = int'(cnt1);
      end
      2: begin
        v_ir = ir5; v_ov = ov5; v_none = none5; v_last = last5;
        v_idx = int'(idx5); v_cnt = int'(cnt5);
      end
      default: ;
    endcase
  end

  assert property (@(posedge clk) disable iff (rst) (v_ov && !out_ready) |=> v_ov)
    else $error("FAIL stall_hold: out_valid dropped while a beat was stalled");

  // exp holds the expected index of beat b in nibble b.
  typedef struct {
    int          sel;
    logic [7:0]  data;
    bit          msb;
    bit          tog;
    int          nb;
    logic [31:0] exp;
  } tv_t;

  tv_t tbl[$];
  int  nvec = 0;
  int  nmis = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s (sel %0d, t=%0t): got %0d, want %0d", name, sel, $time, act, exp);
    end
  endtask

  task automatic run_vec(input tv_t tv);
    int b, cyc, e;
    bit rdy, ok;
    sel = tv.sel;
    in_data = tv.data;
    in_msb_first = tv.msb;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (v_ir) ok = 1'b1;
    end
    chk("in_ready_idle", int'(ok), 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    b = 0;
    cyc = 0;
    while (b < tv.nb && cyc < 40) begin
      @(negedge clk);
      rdy = tv.tog ? (cyc % 2 == 0) : 1'b1;
      out_ready = rdy;
      e = int'((tv.exp >> (4 * b)) & 32'hF);
      chk("out_valid", int'(v_ov), 1);
      chk("in_ready_scan", int'(v_ir), 0);
      chk("out_idx", v_idx, e);
      chk("out_cnt", v_cnt, (tv.data == 8'h00) ? 0 : b + 1);
      chk("out_none", int'(v_none), int'(tv.data == 8'h00));
      chk("out_last", int'(v_last), int'(b == tv.nb - 1));
      if (rdy) b++;
      cyc++;
    end
    chk("beat_count", b, tv.nb);
    @(negedge clk);
    out_ready = 1'b1;
    chk("out_valid_after", int'(v_ov), 0);
    chk("in_ready_after", int'(v_ir), 1);
  endtask

  // Reset mid-scan, then confirm a clean restart with the top bit MSB-first.
  task automatic reset_seq(input int s, input int w);
    int  pre;
    tv_t tv;
    pre = (w > 2) ? 2 : w - 1;
    sel = s;
    in_data = 8'((1 << w) - 1);
    in_msb_first = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rs_ready", int'(v_ir), 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int b = 0; b < pre; b++) begin
      @(negedge clk);
      chk("rs_idx", v_idx, b);
    end
    @(negedge clk);
    chk("rs_scan", int'(v_ov), 1);
    chk("rs_idx_stop", v_idx, pre);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rs_ov_in_rst", int'(v_ov), 0);
    chk("rs_ir_in_rst", int'(v_ir), 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rs_ov_after", int'(v_ov), 0);
    chk("rs_ir_after", int'(v_ir), 1);
    tv = '{s, 8'(1 << (w - 1)), 1'b1, 1'b0, 1, 32'(w - 1)};
    run_vec(tv);
  endtask

  initial begin
    // WIDTH=8
    for (int i = 0; i < 8; i++) tbl.push_back('{0, 8'(1 << i), 1'b0, 1'b0, 1, 32'(i)});
    tbl.push_back('{0, 8'hA6, 1'b0, 1'b0, 4, 32'h0000_7521});
    tbl.push_back('{0, 8'hA6, 1'b1, 1'b0, 4, 32'h0000_1257});
    tbl.push_back('{0, 8'h00, 1'b0, 1'b0, 1, 32'h0});
    tbl.push_back('{0, 8'hFF, 1'b0, 1'b1, 8, 32'h7654_3210});
    // WIDTH=1
    tbl.push_back('{1, 8'h01, 1'b0, 1'b0, 1, 32'h0});
    tbl.push_back('{1, 8'h01, 1'b1, 1'b0, 1, 32'h0});
    tbl.push_back('{1, 8'h00, 1'b0, 1'b0, 1, 32'h0});
    tbl.push_back('{1, 8'h01, 1'b0, 1'b1, 1, 32'h0});
    // WIDTH=5
    for (int i = 0; i < 5; i++) tbl.push_back('{2, 8'(1 << i), 1'b0, 1'b0, 1, 32'(i)});
    tbl.push_back('{2, 8'h16, 1'b0, 1'b0, 3, 32'h0000_0421});
    tbl.push_back('{2, 8'h16, 1'b1, 1'b0, 3, 32'h0000_0124});
    tbl.push_back('{2, 8'h00, 1'b0, 1'b0, 1, 32'h0});
    tbl.push_back('{2, 8'h1F, 1'b0, 1'b1, 5, 32'h0004_3210});

    // Outputs gated during reset, idle values once released.
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_in_ready", int'(v_ir), 0);
      chk("rst_out_valid", int'(v_ov), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("idle_in_ready", int'(v_ir), 1);
      chk("idle_out_valid", int'(v_ov), 0);
      chk("idle_idx", v_idx, 0);
      chk("idle_cnt", v_cnt, 0);
      chk("idle_none", int'(v_none), 0);
      chk("idle_last", int'(v_last), 0);
    end

    foreach (tbl[i]) run_vec(tbl[i]);

    // in_valid held high through a scan: the next vector is taken only after IDLE returns.
    sel = 0;
    in_data = 8'h03;
    in_msb_first = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ov_ready", int'(v_ir), 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 8'h10;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      chk("ov_valid", int'(v_ov), 1);
      chk("ov_in_ready", int'(v_ir), 0);
      chk("ov_idx", v_idx, b);
      chk("ov_last", int'(v_last), int'(b == 1));
    end
    @(negedge clk);
    chk("ov_gap_valid", int'(v_ov), 0);
    chk("ov_gap_ready", int'(v_ir), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ov_next_valid", int'(v_ov), 1);
    chk("ov_next_idx", v_idx, 4);
    chk("ov_next_cnt", v_cnt, 1);
    chk("ov_next_last", int'(v_last), 1);
    @(negedge clk);
    chk("ov_done", int'(v_ov), 0);

    reset_seq(0, 8);
    reset_seq(1, 1);
    reset_seq(2, 5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
